rv_shm_axil_port: RTL and testbench

- AXI4-Lite slave that drives port B of the shared RV32/host true-dual-port memory, giving the host processor word access to it.
- Converts AXI4-Lite read and write transactions into single-cycle memory enable, byte-write and address strobes.
- Captures the memory's 1-cycle read data into an R-channel register.
- Sits between the host interconnect and the shared-memory port B; the RV32 core owns port A.

---
 rtl/rv_shm_axil_port_if.sv | 39 +++
 rtl/rv_shm_axil_port.sv | 130 +++++++++++++
 tb/tb_rv_shm_axil_port.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_shm_axil_port_if.sv
// AXI4-Lite bundle between the host interconnect and the shared-memory port.
// Signal names match the bus pins so both sides read like the AXI channel list.
interface rv_shm_axil_port_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8
);
    logic [ADDR_WIDTH+1:0]          s_awaddr;
    logic                           s_awvalid;
    logic                           s_awready;
    logic [NUM_COL*COL_WIDTH-1:0]   s_wdata;
    logic [NUM_COL-1:0]             s_wstrb;
    logic                           s_wvalid;
    logic                           s_wready;
    logic [1:0]                     s_bresp;
    logic                           s_bvalid;
    logic                           s_bready;
    logic [ADDR_WIDTH+1:0]          s_araddr;
    logic                           s_arvalid;
    logic                           s_arready;
    logic [NUM_COL*COL_WIDTH-1:0]   s_rdata;
    logic [1:0]                     s_rresp;
    logic                           s_rvalid;
    logic                           s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
        output s_bready, s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
        input  s_bready, s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/rv_shm_axil_port.sv
// AXI4-Lite slave driving port B of the RV32/host shared memory.
// Define RV_SHM_AXIL_DOORBELL_EN to add the irq mailbox doorbell.
module rv_shm_axil_port #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    rv_shm_axil_port_if.slave             s,
    output logic                          shm_ena,
    output logic [NUM_COL-1:0]            shm_we,
    output logic [ADDR_WIDTH-1:0]         shm_addr,
    output logic [NUM_COL*COL_WIDTH-1:0]  shm_din,
    input  logic [NUM_COL*COL_WIDTH-1:0]  shm_dout
`ifdef RV_SHM_AXIL_DOORBELL_EN
    ,
    output logic                          irq
`endif
);
    localparam int DW = NUM_COL * COL_WIDTH;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WACC  = 3'd1;
    localparam logic [2:0] BRESP = 3'd2;
    localparam logic [2:0] RACC  = 3'd3;
    localparam logic [2:0] RCAP  = 3'd4;
    localparam logic [2:0] RRESP = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          last_rd_q, last_rd_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_pend, rd_pend;

    // Byte-offset bits carry no meaning for word access.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s.s_awaddr[1:0], s.s_araddr[1:0]};

    assign wr_pend = s.s_awvalid && s.s_wvalid;
    assign rd_pend = s.s_arvalid;

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                // On a tie, alternate so neither direction starves.
                if (wr_pend && rd_pend)
                    state_d = last_rd_q ? WACC : RACC;
                else if (wr_pend)
                    state_d = WACC;
                else if (rd_pend)
                    state_d = RACC;
            end
            WACC: begin
                last_rd_d = 1'b0;
                state_d   = BRESP;
            end
            BRESP: begin
                if (s.s_bready)
                    state_d = IDLE;
            end
            RACC: begin
                last_rd_d = 1'b1;
                state_d   = RCAP;
            end
            RCAP: begin
                rdata_d  = shm_dout;
                rvalid_d = 1'b1;
                state_d  = RRESP;
            end
            RRESP: begin
                if (s.s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s.s_awready = (state_q == WACC);
    assign s.s_wready  = (state_q == WACC);
    assign s.s_bvalid  = (state_q == BRESP);
    assign s.s_bresp   = 2'b00;
    assign s.s_arready = (state_q == RACC);
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = 2'b00;

    assign shm_ena  = (state_q == WACC) || (state_q == RACC);
    assign shm_we   = (state_q == WACC) ? s.s_wstrb : '0;
    assign shm_addr = (state_q == RACC) ? s.s_araddr[ADDR_WIDTH+1:2]
                                        : s.s_awaddr[ADDR_WIDTH+1:2];
    assign shm_din  = s.s_wdata;

`ifdef RV_SHM_AXIL_DOORBELL_EN
    logic irq_q, irq_d;

    // Top word is the mailbox; lane 0 carries the post flag.
    assign irq_d = (state_q == WACC) && (&s.s_awaddr[ADDR_WIDTH+1:2])
                   && s.s_wstrb[0];

    always_ff @(posedge clk) begin
        if (reset)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_rv_shm_axil_port.sv
// Directed bench for rv_shm_axil_port with a read-first memory model on port B.
// Doorbell checks are built only when RV_SHM_AXIL_DOORBELL_EN is defined.
module tb_rv_shm_axil_port;
    logic        clk;
    logic        reset;
    logic        shm_ena;
    logic [3:0]  shm_we;
    logic [5:0]  shm_addr;
    logic [31:0] shm_din;
    logic [31:0] shm_dout;
`ifdef RV_SHM_AXIL_DOORBELL_EN
    logic        irq;
`endif

    int nvec = 0;
    int nerr = 0;

    rv_shm_axil_port_if #(.ADDR_WIDTH(6), .NUM_COL(4), .COL_WIDTH(8)) axi ();

    rv_shm_axil_port #(.ADDR_WIDTH(6), .NUM_COL(4), .COL_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (axi),
        .shm_ena  (shm_ena),
        .shm_we   (shm_we),
        .shm_addr (shm_addr),
        .shm_din  (shm_din),
        .shm_dout (shm_dout)
`ifdef RV_SHM_AXIL_DOORBELL_EN
        ,
        .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first true-dual-port memory, port B only.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (shm_ena) begin
            shm_dout <= mem[shm_addr];
            for (int b = 0; b < 4; b++)
                if (shm_we[b])
                    mem[shm_addr][b*8 +: 8] <= shm_din[b*8 +: 8];
        end
    end

    task automatic stepn();
        @(negedge clk);
    endtask

    // Stimulus only: one full write from IDLE back to IDLE.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] st);
        axi.s_awaddr = a; axi.s_wdata = d; axi.s_wstrb = st;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        stepn();
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
    endtask

    // Stimulus only: one full read, returns the R-channel data.
    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        axi.s_araddr = a; axi.s_arvalid = 1'b1;
        stepn();
        stepn();
        axi.s_arvalid = 1'b0;
        stepn();
        d = axi.s_rdata;
        axi.s_rready = 1'b1;
        stepn();
        axi.s_rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) stepn();
        nvec++; if (axi.s_awready !== 1'b0) begin nerr++; $display("FAIL rst_awready got %b want 0", axi.s_awready); end
        nvec++; if (axi.s_wready !== 1'b0) begin nerr++; $display("FAIL rst_wready got %b want 0", axi.s_wready); end
        nvec++; if (axi.s_arready !== 1'b0) begin nerr++; $display("FAIL rst_arready got %b want 0", axi.s_arready); end
        nvec++; if (axi.s_bvalid !== 1'b0) begin nerr++; $display("FAIL rst_bvalid got %b want 0", axi.s_bvalid); end
        nvec++; if (axi.s_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_rvalid got %b want 0", axi.s_rvalid); end
        nvec++; if (axi.s_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", axi.s_rdata); end
        nvec++; if (shm_ena !== 1'b0) begin nerr++; $display("FAIL rst_ena got %b want 0", shm_ena); end
        nvec++; if (shm_we !== 4'h0) begin nerr++; $display("FAIL rst_we got %h want 0", shm_we); end
`ifdef RV_SHM_AXIL_DOORBELL_EN
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL rst_irq got %b want 0", irq); end
`endif
        reset = 1'b0;
        stepn();
    endtask

    task automatic test_write_read();
        axi.s_awaddr = 8'h08; axi.s_wdata = 32'hDEADBEEF; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        stepn();
        nvec++; if ({axi.s_awready, axi.s_wready} !== 2'b11) begin nerr++; $display("FAIL wacc_ready got %b want 11", {axi.s_awready, axi.s_wready}); end
        nvec++; if (shm_ena !== 1'b1) begin nerr++; $display("FAIL wacc_ena got %b want 1", shm_ena); end
        nvec++; if (shm_addr !== 6'd2) begin nerr++; $display("FAIL wacc_addr got %0d want 2", shm_addr); end
        nvec++; if (shm_we !== 4'hF) begin nerr++; $display("FAIL wacc_we got %h want f", shm_we); end
        nvec++; if (shm_din !== 32'hDEADBEEF) begin nerr++; $display("FAIL wacc_din got %h want deadbeef", shm_din); end
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        nvec++; if (axi.s_bvalid !== 1'b1) begin nerr++; $display("FAIL bresp_bvalid got %b want 1", axi.s_bvalid); end
        nvec++; if (axi.s_bresp !== 2'b00) begin nerr++; $display("FAIL bresp_code got %b want 00", axi.s_bresp); end
        nvec++; if (shm_ena !== 1'b0) begin nerr++; $display("FAIL bresp_ena got %b want 0", shm_ena); end
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
        nvec++; if (axi.s_bvalid !== 1'b0) begin nerr++; $display("FAIL b_done got %b want 0", axi.s_bvalid); end
        axi.s_araddr = 8'h08; axi.s_arvalid = 1'b1;
        stepn();
        nvec++; if (axi.s_arready !== 1'b1) begin nerr++; $display("FAIL racc_arready got %b want 1", axi.s_arready); end
        nvec++; if ({shm_ena, shm_we} !== 5'b10000) begin nerr++; $display("FAIL racc_ena_we got %b want 10000", {shm_ena, shm_we}); end
        nvec++; if (shm_addr !== 6'd2) begin nerr++; $display("FAIL racc_addr got %0d want 2", shm_addr); end
        stepn();
        axi.s_arvalid = 1'b0;
        nvec++; if ({axi.s_arready, axi.s_rvalid} !== 2'b00) begin nerr++; $display("FAIL rcap_flags got %b want 00", {axi.s_arready, axi.s_rvalid}); end
        stepn();
        nvec++; if (axi.s_rvalid !== 1'b1) begin nerr++; $display("FAIL rresp_rvalid got %b want 1", axi.s_rvalid); end
        nvec++; if (axi.s_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rresp_rdata got %h want deadbeef", axi.s_rdata); end
        nvec++; if (axi.s_rresp !== 2'b00) begin nerr++; $display("FAIL rresp_code got %b want 00", axi.s_rresp); end
        axi.s_rready = 1'b1;
        stepn();
        axi.s_rready = 1'b0;
        nvec++; if (axi.s_rvalid !== 1'b0) begin nerr++; $display("FAIL r_done got %b want 0", axi.s_rvalid); end
    endtask

    task automatic test_byte_write();
        logic [31:0] d;
        do_write(8'h08, 32'h11223344, 4'b0101);
        do_read(8'h08, d);
        nvec++; if (d !== 32'hDE22BE44) begin nerr++; $display("FAIL byte_merge got %h want de22be44", d); end
    endtask

    task automatic test_arbitration();
        reset = 1'b1;
        stepn();
        reset = 1'b0;
        axi.s_awaddr = 8'h10; axi.s_wdata = 32'hCAFEF00D; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        axi.s_araddr = 8'h08; axi.s_arvalid = 1'b1;
        stepn();
        nvec++; if ({axi.s_arready, axi.s_awready, axi.s_wready} !== 3'b100) begin nerr++; $display("FAIL arb1_read_first got %b want 100", {axi.s_arready, axi.s_awready, axi.s_wready}); end
        stepn();
        axi.s_arvalid = 1'b0;
        stepn();
        nvec++; if (axi.s_rdata !== 32'hDE22BE44) begin nerr++; $display("FAIL arb1_rdata got %h want de22be44", axi.s_rdata); end
        axi.s_rready = 1'b1;
        axi.s_araddr = 8'h10; axi.s_arvalid = 1'b1;
        stepn();
        axi.s_rready = 1'b0;
        stepn();
        nvec++; if ({axi.s_arready, axi.s_awready, axi.s_wready} !== 3'b011) begin nerr++; $display("FAIL arb2_write_first got %b want 011", {axi.s_arready, axi.s_awready, axi.s_wready}); end
        nvec++; if (shm_addr !== 6'd4) begin nerr++; $display("FAIL arb2_waddr got %0d want 4", shm_addr); end
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
        stepn();
        nvec++; if (axi.s_arready !== 1'b1) begin nerr++; $display("FAIL arb2_read_next got %b want 1", axi.s_arready); end
        stepn();
        axi.s_arvalid = 1'b0;
        stepn();
        nvec++; if (axi.s_rdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL arb2_rdata got %h want cafef00d", axi.s_rdata); end
        axi.s_rready = 1'b1;
        stepn();
        axi.s_rready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        axi.s_araddr = 8'h10; axi.s_arvalid = 1'b1;
        stepn();
        stepn();
        stepn();
        for (int i = 0; i < 5; i++) begin
            nvec++; if ({axi.s_rvalid, axi.s_arready} !== 2'b10) begin nerr++; $display("FAIL bp_r_flags[%0d] got %b want 10", i, {axi.s_rvalid, axi.s_arready}); end
            nvec++; if (axi.s_rdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL bp_rdata[%0d] got %h want cafef00d", i, axi.s_rdata); end
            stepn();
        end
        axi.s_rready = 1'b1; axi.s_arvalid = 1'b0;
        stepn();
        axi.s_rready = 1'b0;
        nvec++; if (axi.s_rvalid !== 1'b0) begin nerr++; $display("FAIL bp_r_done got %b want 0", axi.s_rvalid); end
        axi.s_awaddr = 8'h0C; axi.s_wdata = 32'h0BADC0DE; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        stepn();
        stepn();
        for (int i = 0; i < 5; i++) begin
            nvec++; if ({axi.s_bvalid, axi.s_awready, axi.s_wready} !== 3'b100) begin nerr++; $display("FAIL bp_b_flags[%0d] got %b want 100", i, {axi.s_bvalid, axi.s_awready, axi.s_wready}); end
            stepn();
        end
        axi.s_bready = 1'b1; axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        stepn();
        axi.s_bready = 1'b0;
        nvec++; if (axi.s_bvalid !== 1'b0) begin nerr++; $display("FAIL bp_b_done got %b want 0", axi.s_bvalid); end
        do_read(8'h0C, d);
        nvec++; if (d !== 32'h0BADC0DE) begin nerr++; $display("FAIL bp_wdata_back got %h want 0badc0de", d); end
    endtask

    task automatic test_lone_aw();
        axi.s_awaddr = 8'h14; axi.s_wdata = 32'h5A5A1234; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepn();
            nvec++; if ({axi.s_awready, axi.s_wready, shm_ena} !== 3'b000) begin nerr++; $display("FAIL lone_aw[%0d] got %b want 000", i, {axi.s_awready, axi.s_wready, shm_ena}); end
        end
        axi.s_wvalid = 1'b1;
        stepn();
        nvec++; if ({axi.s_awready, axi.s_wready} !== 2'b11) begin nerr++; $display("FAIL lone_aw_join got %b want 11", {axi.s_awready, axi.s_wready}); end
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        nvec++; if ({axi.s_awready, axi.s_bvalid} !== 2'b01) begin nerr++; $display("FAIL lone_aw_pulse got %b want 01", {axi.s_awready, axi.s_bvalid}); end
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
    endtask

`ifdef RV_SHM_AXIL_DOORBELL_EN
    task automatic test_doorbell();
        axi.s_awaddr = 8'hFC; axi.s_wdata = 32'h00000001; axi.s_wstrb = 4'h1;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        stepn();
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL db_wacc got %b want 0", irq); end
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL db_pulse got %b want 1", irq); end
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL db_end got %b want 0", irq); end
        axi.s_awaddr = 8'hF8; axi.s_wstrb = 4'hF;
        axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
        stepn();
        stepn();
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL db_other_word got %b want 0", irq); end
        axi.s_bready = 1'b1;
        stepn();
        axi.s_bready = 1'b0;
    endtask
`endif

    task automatic test_reset_rresp();
        axi.s_araddr = 8'h0C; axi.s_arvalid = 1'b1;
        stepn();
        stepn();
        axi.s_arvalid = 1'b0;
        stepn();
        nvec++; if (axi.s_rvalid !== 1'b1) begin nerr++; $display("FAIL rr_pre got %b want 1", axi.s_rvalid); end
        reset = 1'b1;
        stepn();
        reset = 1'b0;
        nvec++; if (axi.s_rvalid !== 1'b0) begin nerr++; $display("FAIL rr_rvalid got %b want 0", axi.s_rvalid); end
        nvec++; if (dut.state_q !== 3'd0) begin nerr++; $display("FAIL rr_state got %0d want 0", dut.state_q); end
        nvec++; if (axi.s_rdata !== 32'h0) begin nerr++; $display("FAIL rr_rdata got %h want 0", axi.s_rdata); end
        stepn();
        nvec++; if ({axi.s_arready, axi.s_awready, shm_ena} !== 3'b000) begin nerr++; $display("FAIL rr_idle got %b want 000", {axi.s_arready, axi.s_awready, shm_ena}); end
    endtask

    initial begin
        reset = 1'b1;
        axi.s_awaddr = '0; axi.s_awvalid = 1'b0;
        axi.s_wdata = '0; axi.s_wstrb = '0; axi.s_wvalid = 1'b0;
        axi.s_bready = 1'b0;
        axi.s_araddr = '0; axi.s_arvalid = 1'b0;
        axi.s_rready = 1'b0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_arbitration();
        test_backpressure();
        test_lone_aw();
`ifdef RV_SHM_AXIL_DOORBELL_EN
        test_doorbell();
`endif
        test_reset_rresp();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
